// File: rtl/sram_write_cmd_sequencer.sv
// Allocates one SRAM write collector for front-pad/DRAM-body/back-pad fill, then streams its commands.
// Latency: req->alloc 1 cycle, alloc->first cmd 1 cycle; alloc_rdy/cmd_rdy and their fields hold until acked.
module sram_write_cmd_sequencer #(
  parameter int DBW     = 16,
  parameter int VSIZE   = 32,
  parameter int CSIZE   = 32,
  parameter int LBW     = 10,
  parameter int ICFG_BW = 3,
  parameter int CV_BW1  = $clog2(VSIZE + 1),
  parameter int CC_BW   = $clog2(CSIZE)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               req_rdy,
  output logic               req_ack,
  input  logic               i_which,
  input  logic [ICFG_BW-1:0] i_id,
  input  logic [DBW-1:0]     i_padv,
  input  logic [LBW:0]       i_nfront,
  input  logic [LBW:0]       i_nbody,
  input  logic [LBW:0]       i_nback,
  input  logic [CC_BW-1:0]   i_ofs,
  output logic               alloc_rdy,
  input  logic               alloc_ack,
  output logic [ICFG_BW-1:0] o_id,
  output logic [LBW:0]       o_size,
  output logic [DBW-1:0]     o_padv,
  output logic               cmd_rdy,
  input  logic               cmd_ack,
  output logic               o_which,
  output logic [1:0]         o_cmd_type,
  output logic               o_cmd_islast,
  output logic [CC_BW-1:0]   o_cmd_addrofs,
  output logic [CV_BW1-1:0]  o_cmd_len
);

  localparam int LW = LBW + 1;

  typedef enum logic [2:0] {IDLE, ALLOC, FRONT, BODY, BACK} state_t;
  typedef logic [LW-1:0] cnt_t;

  typedef struct packed {
    logic [1:0]        typ;
    logic [CV_BW1-1:0] len;
    logic [CC_BW-1:0]  addrofs;
    logic              islast;
  } cmd_t;

  localparam cnt_t VSIZE_C = cnt_t'(VSIZE);
  localparam cnt_t CSIZE_C = cnt_t'(CSIZE);

  state_t           state, nxt_state;
  cnt_t             cnt_front, cnt_body, cnt_back;
  cnt_t             nxt_front, nxt_body, nxt_back;
  logic [CC_BW-1:0] ofs_q, nxt_ofs;
  cmd_t             cmd_q, nxt_cmd;
  cnt_t             sum, cur_len;

  // First non-empty section at or after 'from'; IDLE when everything is drained.
  function automatic state_t first_sect(state_t from, cnt_t f, cnt_t b, cnt_t k);
    if (from == FRONT && f != '0) return FRONT;
    if (from != BACK && b != '0) return BODY;
    if (k != '0) return BACK;
    return IDLE;
  endfunction

  function automatic cmd_t make_cmd(state_t s, cnt_t f, cnt_t b, cnt_t k, logic [CC_BW-1:0] ofs);
    cmd_t c;
    cnt_t left, room, len, ofs_w;
    c     = '0;
    ofs_w = cnt_t'(ofs);
    if (s == BODY) begin
      left = b;
      room = CSIZE_C - ofs_w;
      len  = (left < room) ? left : room;
      if (len > VSIZE_C) len = VSIZE_C;
      c.typ     = 2'd0;
      c.addrofs = ofs;
      // A short final chunk still releases its DRAM line.
      c.islast  = ((ofs_w + len) == CSIZE_C) || (len == left);
    end else begin
      left  = (s == FRONT) ? f : k;
      len   = (left < VSIZE_C) ? left : VSIZE_C;
      c.typ = 2'd2;
    end
    c.len = CV_BW1'(len);
    return c;
  endfunction

  assign req_ack = (state == IDLE) && req_rdy;
  assign cur_len = cnt_t'(cmd_q.len);

  always_comb begin
    nxt_state = state;
    nxt_front = cnt_front;
    nxt_body  = cnt_body;
    nxt_back  = cnt_back;
    nxt_ofs   = ofs_q;
    sum       = i_nfront + i_nbody + i_nback;
    case (state)
      IDLE: if (req_rdy) begin
        nxt_front = i_nfront;
        nxt_body  = i_nbody;
        nxt_back  = i_nback;
        nxt_ofs   = i_ofs;
        // A zero-size allocation would hang the collector, so drop it here.
        nxt_state = (sum == '0) ? IDLE : ALLOC;
      end
      ALLOC: if (alloc_ack) nxt_state = first_sect(FRONT, cnt_front, cnt_body, cnt_back);
      FRONT: if (cmd_ack) begin
        nxt_front = cnt_front - cur_len;
        nxt_state = first_sect(FRONT, nxt_front, cnt_body, cnt_back);
      end
      BODY: if (cmd_ack) begin
        nxt_body  = cnt_body - cur_len;
        nxt_ofs   = ofs_q + CC_BW'(cmd_q.len);
        nxt_state = first_sect(BODY, cnt_front, nxt_body, cnt_back);
      end
      BACK: if (cmd_ack) begin
        nxt_back  = cnt_back - cur_len;
        nxt_state = first_sect(BACK, cnt_front, cnt_body, nxt_back);
      end
      default: nxt_state = IDLE;
    endcase
    nxt_cmd = make_cmd(nxt_state, nxt_front, nxt_body, nxt_back, nxt_ofs);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      cnt_front <= '0;
      cnt_body  <= '0;
      cnt_back  <= '0;
      ofs_q     <= '0;
      cmd_q     <= '0;
      alloc_rdy <= 1'b0;
      cmd_rdy   <= 1'b0;
      o_which   <= 1'b0;
      o_id      <= '0;
      o_padv    <= '0;
      o_size    <= '0;
    end else begin
      state     <= nxt_state;
      cnt_front <= nxt_front;
      cnt_body  <= nxt_body;
      cnt_back  <= nxt_back;
      ofs_q     <= nxt_ofs;
      alloc_rdy <= (nxt_state == ALLOC);
      cmd_rdy   <= (nxt_state inside {FRONT, BODY, BACK});
      if (nxt_state inside {FRONT, BODY, BACK}) cmd_q <= nxt_cmd;
      if (req_ack) begin
        o_which <= i_which;
        o_id    <= i_id;
        o_padv  <= i_padv;
        o_size  <= sum;
      end
    end
  end

  assign o_cmd_type    = cmd_q.typ;
  assign o_cmd_len     = cmd_q.len;
  assign o_cmd_addrofs = cmd_q.addrofs;
  assign o_cmd_islast  = cmd_q.islast;

endmodule

// File: tb/tb_sram_write_cmd_sequencer.sv
// Directed bench for sram_write_cmd_sequencer: section sequencing, stalls, zero-size and mid-run reset.
module tb_sram_write_cmd_sequencer;

  logic        i_clk, i_rst;
  logic        req_rdy, req_ack, i_which;
  logic [2:0]  i_id;
  logic [15:0] i_padv;
  logic [10:0] i_nfront, i_nbody, i_nback;
  logic [4:0]  i_ofs;
  logic        alloc_rdy, alloc_ack;
  logic [2:0]  o_id;
  logic [10:0] o_size;
  logic [15:0] o_padv;
  logic        cmd_rdy, cmd_ack, o_which;
  logic [1:0]  o_cmd_type;
  logic        o_cmd_islast;
  logic [4:0]  o_cmd_addrofs;
  logic [5:0]  o_cmd_len;

  int n_tests = 0;
  int n_fail  = 0;

  sram_write_cmd_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .req_rdy(req_rdy), .req_ack(req_ack),
    .i_which(i_which), .i_id(i_id), .i_padv(i_padv),
    .i_nfront(i_nfront), .i_nbody(i_nbody), .i_nback(i_nback), .i_ofs(i_ofs),
    .alloc_rdy(alloc_rdy), .alloc_ack(alloc_ack),
    .o_id(o_id), .o_size(o_size), .o_padv(o_padv),
    .cmd_rdy(cmd_rdy), .cmd_ack(cmd_ack), .o_which(o_which),
    .o_cmd_type(o_cmd_type), .o_cmd_islast(o_cmd_islast),
    .o_cmd_addrofs(o_cmd_addrofs), .o_cmd_len(o_cmd_len)
  );

  // {rdy, type, len, addrofs, islast, which}
  wire [15:0] cmd_view = {cmd_rdy, o_cmd_type, o_cmd_len, o_cmd_addrofs, o_cmd_islast, o_which};
  wire [46:0] all_view = {alloc_rdy, cmd_rdy, o_id, o_size, o_padv, o_which,
                          o_cmd_type, o_cmd_islast, o_cmd_addrofs, o_cmd_len};

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic drive_req(input logic w, input logic [2:0] id, input logic [15:0] pv,
                           input logic [10:0] nf, input logic [10:0] nb, input logic [10:0] nk,
                           input logic [4:0] of);
    req_rdy = 1'b1; i_which = w; i_id = id; i_padv = pv;
    i_nfront = nf; i_nbody = nb; i_nback = nk; i_ofs = of;
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    n_tests++;
    if (all_view !== 47'd0 || req_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: got %h ack %b want 0", all_view, req_ack);
    end
    i_rst = 1'b1;
  endtask

  task automatic test_mixed();
    logic [15:0] exp_q[$];
    exp_q = '{{1'b1, 2'd2, 6'd3,  5'd0,  1'b0, 1'b1},
              {1'b1, 2'd0, 6'd2,  5'd30, 1'b1, 1'b1},
              {1'b1, 2'd0, 6'd32, 5'd0,  1'b1, 1'b1},
              {1'b1, 2'd0, 6'd6,  5'd0,  1'b1, 1'b1},
              {1'b1, 2'd2, 6'd5,  5'd0,  1'b0, 1'b1}};
    @(negedge i_clk);
    drive_req(1'b1, 3'd2, 16'h00AA, 11'd3, 11'd40, 11'd5, 5'd30);
    #1;
    n_tests++;
    if (req_ack !== 1'b1) begin n_fail++; $display("FAIL mixed_req_ack: got %b want 1", req_ack); end
    @(negedge i_clk);
    req_rdy = 1'b0;
    n_tests++;
    if ({alloc_rdy, cmd_rdy, o_size} !== {1'b1, 1'b0, 11'd48}) begin
      n_fail++; $display("FAIL mixed_alloc: got %b%b size %0d want 1 0 size 48", alloc_rdy, cmd_rdy, o_size);
    end
    alloc_ack = 1'b1;
    @(negedge i_clk);
    alloc_ack = 1'b0;
    cmd_ack   = 1'b1;
    foreach (exp_q[i]) begin
      n_tests++;
      if (cmd_view !== exp_q[i]) begin
        n_fail++; $display("FAIL mixed_cmd%0d: got %h want %h", i, cmd_view, exp_q[i]);
      end
      @(negedge i_clk);
    end
    cmd_ack = 1'b0;
    n_tests++;
    if ({alloc_rdy, cmd_rdy} !== 2'b00) begin
      n_fail++; $display("FAIL mixed_done: got %b%b want 00", alloc_rdy, cmd_rdy);
    end
  endtask

  task automatic test_single_section();
    logic [15:0] exp_q[$];
    logic [10:0] nf, nb, sz;
    logic [4:0]  of;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin
          nf = 11'd70; nb = 11'd0; of = 5'd0; sz = 11'd70;
          exp_q = '{{1'b1, 2'd2, 6'd32, 5'd0, 1'b0, 1'b0},
                    {1'b1, 2'd2, 6'd32, 5'd0, 1'b0, 1'b0},
                    {1'b1, 2'd2, 6'd6,  5'd0, 1'b0, 1'b0}};
        end
        1: begin
          nf = 11'd0; nb = 11'd64; of = 5'd0; sz = 11'd64;
          exp_q = '{{1'b1, 2'd0, 6'd32, 5'd0, 1'b1, 1'b0},
                    {1'b1, 2'd0, 6'd32, 5'd0, 1'b1, 1'b0}};
        end
        default: begin
          nf = 11'd0; nb = 11'd5; of = 5'd10; sz = 11'd5;
          exp_q = '{{1'b1, 2'd0, 6'd5, 5'd10, 1'b1, 1'b0}};
        end
      endcase
      @(negedge i_clk);
      drive_req(1'b0, 3'd1, 16'h1234, nf, nb, 11'd0, of);
      #1;
      n_tests++;
      if (req_ack !== 1'b1) begin n_fail++; $display("FAIL single%0d_req_ack: got %b want 1", c, req_ack); end
      @(negedge i_clk);
      req_rdy = 1'b0;
      n_tests++;
      if ({alloc_rdy, cmd_rdy, o_size} !== {1'b1, 1'b0, sz}) begin
        n_fail++; $display("FAIL single%0d_alloc: got %b%b size %0d want 1 0 size %0d", c, alloc_rdy, cmd_rdy, o_size, sz);
      end
      alloc_ack = 1'b1;
      @(negedge i_clk);
      alloc_ack = 1'b0;
      cmd_ack   = 1'b1;
      foreach (exp_q[i]) begin
        n_tests++;
        if (cmd_view !== exp_q[i]) begin
          n_fail++; $display("FAIL single%0d_cmd%0d: got %h want %h", c, i, cmd_view, exp_q[i]);
        end
        @(negedge i_clk);
      end
      cmd_ack = 1'b0;
      n_tests++;
      if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL single%0d_done: got %b want 0", c, cmd_rdy); end
    end
  endtask

  task automatic test_zero();
    @(negedge i_clk);
    drive_req(1'b1, 3'd7, 16'hFFFF, 11'd0, 11'd0, 11'd0, 5'd4);
    #1;
    n_tests++;
    if (req_ack !== 1'b1) begin n_fail++; $display("FAIL zero_req_ack: got %b want 1", req_ack); end
    @(negedge i_clk);
    req_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({alloc_rdy, cmd_rdy} !== 2'b00) begin
        n_fail++; $display("FAIL zero_no_alloc%0d: got %b%b want 00", i, alloc_rdy, cmd_rdy);
      end
      @(negedge i_clk);
    end
    // Still idle: a request is acknowledged at once (withdrawn before the edge).
    req_rdy = 1'b1;
    #1;
    n_tests++;
    if (req_ack !== 1'b1) begin n_fail++; $display("FAIL zero_idle: got %b want 1", req_ack); end
    req_rdy = 1'b0;
  endtask

  task automatic test_stall();
    logic [15:0] exp_q[$];
    exp_q = '{{1'b1, 2'd0, 6'd32, 5'd0, 1'b1, 1'b1},
              {1'b1, 2'd0, 6'd6,  5'd0, 1'b1, 1'b1}};
    @(negedge i_clk);
    drive_req(1'b1, 3'd5, 16'hBEEF, 11'd0, 11'd70, 11'd0, 5'd0);
    @(negedge i_clk);
    req_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({alloc_rdy, cmd_rdy, o_id, o_size, o_padv} !== {1'b1, 1'b0, 3'd5, 11'd70, 16'hBEEF}) begin
        n_fail++; $display("FAIL stall_alloc%0d: got %b%b id %0d size %0d padv %h want 1 0 id 5 size 70 padv beef",
                           i, alloc_rdy, cmd_rdy, o_id, o_size, o_padv);
      end
      if (i == 3) alloc_ack = 1'b1;
      @(negedge i_clk);
    end
    alloc_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (cmd_view !== {1'b1, 2'd0, 6'd32, 5'd0, 1'b1, 1'b1}) begin
        n_fail++; $display("FAIL stall_hold%0d: got %h want %h", i, cmd_view, {1'b1, 2'd0, 6'd32, 5'd0, 1'b1, 1'b1});
      end
      if (i == 5) cmd_ack = 1'b1;
      @(negedge i_clk);
    end
    foreach (exp_q[i]) begin
      n_tests++;
      if (cmd_view !== exp_q[i]) begin
        n_fail++; $display("FAIL stall_b2b%0d: got %h want %h", i, cmd_view, exp_q[i]);
      end
      @(negedge i_clk);
    end
    cmd_ack = 1'b0;
    n_tests++;
    if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_done: got %b want 0", cmd_rdy); end
  endtask

  task automatic test_reset_mid();
    @(negedge i_clk);
    drive_req(1'b1, 3'd3, 16'h5555, 11'd0, 11'd100, 11'd0, 5'd3);
    @(negedge i_clk);
    req_rdy   = 1'b0;
    alloc_ack = 1'b1;
    @(negedge i_clk);
    alloc_ack = 1'b0;
    n_tests++;
    if (cmd_view !== {1'b1, 2'd0, 6'd29, 5'd3, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL rmid_cmd0: got %h want %h", cmd_view, {1'b1, 2'd0, 6'd29, 5'd3, 1'b1, 1'b1});
    end
    cmd_ack = 1'b1;
    @(negedge i_clk);
    cmd_ack = 1'b0;
    n_tests++;
    if (cmd_view !== {1'b1, 2'd0, 6'd32, 5'd0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL rmid_cmd1: got %h want %h", cmd_view, {1'b1, 2'd0, 6'd32, 5'd0, 1'b1, 1'b1});
    end
    i_rst = 1'b0;
    #1;
    n_tests++;
    if (all_view !== 47'd0) begin n_fail++; $display("FAIL rmid_async_clear: got %h want 0", all_view); end
    @(negedge i_clk);
    i_rst = 1'b1;
    n_tests++;
    if (all_view !== 47'd0) begin n_fail++; $display("FAIL rmid_after_reset: got %h want 0", all_view); end
    drive_req(1'b0, 3'd4, 16'h0F0F, 11'd0, 11'd5, 11'd0, 5'd10);
    #1;
    n_tests++;
    if (req_ack !== 1'b1) begin n_fail++; $display("FAIL rmid_req_ack: got %b want 1", req_ack); end
    @(negedge i_clk);
    req_rdy = 1'b0;
    n_tests++;
    if ({alloc_rdy, cmd_rdy, o_size} !== {1'b1, 1'b0, 11'd5}) begin
      n_fail++; $display("FAIL rmid_alloc: got %b%b size %0d want 1 0 size 5", alloc_rdy, cmd_rdy, o_size);
    end
    alloc_ack = 1'b1;
    @(negedge i_clk);
    alloc_ack = 1'b0;
    cmd_ack   = 1'b1;
    n_tests++;
    if (cmd_view !== {1'b1, 2'd0, 6'd5, 5'd10, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL rmid_new_cmd: got %h want %h", cmd_view, {1'b1, 2'd0, 6'd5, 5'd10, 1'b1, 1'b0});
    end
    @(negedge i_clk);
    cmd_ack = 1'b0;
    n_tests++;
    if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b want 0", cmd_rdy); end
  endtask

  initial begin
    i_rst = 1'b0; req_rdy = 1'b0; alloc_ack = 1'b0; cmd_ack = 1'b0;
    i_which = 1'b0; i_id = '0; i_padv = '0;
    i_nfront = '0; i_nbody = '0; i_nback = '0; i_ofs = '0;
    test_reset();
    test_mixed();
    test_single_section();
    test_zero();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
